// File: rtl/lsu_pkg.sv
// Shared constants, encodings and small decode helpers for the load/store unit.
package lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } e_load_f3;

    typedef enum logic [2:0] {
        F3_SB = 3'b000,
        F3_SH = 3'b001,
        F3_SW = 3'b010
    } e_store_f3;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } e_lsu_state;

    // Access size lives in func3[1:0] for both loads and stores.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store) begin
            return f3 inside {F3_SB, F3_SH, F3_SW};
        end
        return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    endfunction

    // Byte offset actually used for lane steering; offset bits a size cannot use are dropped.
    function automatic logic [1:0] lane_offset(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            SIZE_BYTE: return addr_lo;
            SIZE_HALF: return {addr_lo[1], 1'b0};
            default:   return 2'b00;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        return ((f3[1:0] == SIZE_HALF) && addr_lo[0]) ||
               ((f3[1:0] == SIZE_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store enables/data replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [1:0]    st_size_i,
    input  logic [1:0]    st_off_i,
    input  logic [DW-1:0] st_data_i,
    output logic [3:0]    st_be_o,
    output logic [DW-1:0] st_wdata_o,
    input  logic [2:0]    ld_func3_i,
    input  logic [1:0]    ld_off_i,
    input  logic [DW-1:0] ld_rdata_i,
    output logic [DW-1:0] ld_data_o
);

    logic [DW-1:0] shifted;

    always_comb begin
        st_be_o    = 4'b0000;
        st_wdata_o = '0;
        case (st_size_i)
            SIZE_BYTE: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_data_i[7:0]}};
            end
            SIZE_HALF: begin
                st_be_o    = 4'b0011 << {st_off_i[1], 1'b0};
                st_wdata_o = {2{st_data_i[15:0]}};
            end
            SIZE_WORD: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_data_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted   = ld_rdata_i >> {ld_off_i, 3'b000};
        ld_data_o = '0;
        case (ld_func3_i)
            F3_LB:   ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_LBU:  ld_data_o = {24'h000000, shifted[7:0]};
            F3_LH:   ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LHU:  ld_data_o = {16'h0000, shifted[15:0]};
            F3_LW:   ld_data_o = shifted;
            default: ld_data_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: IDLE/BUSY/DONE FSM driving a req/ack bus with lane alignment.
// Optional LSU_MISALIGN_CHECK_EN rejects misaligned half/word accesses without a bus cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_i,
    input  logic [6:0]    opcode_i,
    input  logic [2:0]    func3_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] store_data_i,
    output logic          stall_o,
    output logic [DW-1:0] load_data_o,
    output logic          load_valid_o,
    output logic          err_o,
    output logic          misalign_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [3:0]    mem_be_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i
);

    localparam int CW = $clog2(TIMEOUT + 1);

    e_lsu_state    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    func3_q, func3_d;
    logic [1:0]    off_q, off_d;
    logic          is_load_q, is_load_d;
    logic          err_q, err_d;
    logic          mis_q, mis_d;
    logic [DW-1:0] ld_data_q, ld_data_d;
    logic          req_q, req_d;

    logic          is_load, is_store, accept, legal, misaligned, timed_out;
    logic [1:0]    in_off;
    logic [3:0]    st_be;
    logic [DW-1:0] st_wdata, ld_ext;

    assign is_load   = (opcode_i == OPC_LOAD);
    assign is_store  = (opcode_i == OPC_STORE);
    assign accept    = (state_q == IDLE) && valid_i && (is_load || is_store);
    assign legal     = f3_legal(is_store, func3_i);
    assign in_off    = lane_offset(func3_i, addr_i[1:0]);
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(func3_i, addr_i[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    lsu_align #(.DW(DW)) u_align (
        .st_size_i  (func3_i[1:0]),
        .st_off_i   (in_off),
        .st_data_i  (store_data_i),
        .st_be_o    (st_be),
        .st_wdata_o (st_wdata),
        .ld_func3_i (func3_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (mem_rdata_i),
        .ld_data_o  (ld_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = (legal && !misaligned) ? BUSY : DONE;
            BUSY: if (mem_ack_i || timed_out) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall_o      = 1'b0;
        load_valid_o = 1'b0;
        err_o        = 1'b0;
        misalign_o   = 1'b0;
        case (state_q)
            IDLE: stall_o = accept;
            BUSY: stall_o = 1'b1;
            DONE: begin
                load_valid_o = is_load_q && !err_q && !mis_q;
                err_o        = err_q;
`ifdef LSU_MISALIGN_CHECK_EN
                misalign_o   = mis_q;
`endif
            end
            default: ;
        endcase
    end

    // Every load that finishes without good data leaves zero on load_data_o.
    always_comb begin
        cnt_d     = '0;
        addr_d    = addr_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        func3_d   = func3_q;
        off_d     = off_q;
        is_load_d = is_load_q;
        err_d     = err_q;
        mis_d     = mis_q;
        ld_data_d = ld_data_q;
        req_d     = (state_d == BUSY);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d    = {addr_i[AW-1:2], 2'b00};
                    we_d      = is_store;
                    be_d      = st_be;
                    wdata_d   = st_wdata;
                    func3_d   = func3_i;
                    off_d     = in_off;
                    is_load_d = is_load;
                    err_d     = !legal;
                    mis_d     = legal && misaligned;
                    if (is_load && !(legal && !misaligned)) ld_data_d = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (mem_ack_i) begin
                    if (is_load_q) ld_data_d = ld_ext;
                end else if (timed_out) begin
                    err_d = 1'b1;
                    if (is_load_q) ld_data_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            func3_q   <= 3'b000;
            off_q     <= 2'b00;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            ld_data_q <= '0;
            req_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            func3_q   <= func3_d;
            off_q     <= off_d;
            is_load_q <= is_load_d;
            err_q     <= err_d;
            mis_q     <= mis_d;
            ld_data_q <= ld_data_d;
            req_q     <= req_d;
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign load_data_o = ld_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random loads/stores against an arithmetic model.
module tb_load_store_unit;

    localparam int TMO = 4;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_ALU = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  func3_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        err_o;
    logic        misalign_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] held_ld = 32'h0;

    load_store_unit #(.DW(32), .AW(32), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .opcode_i     (opcode_i),
        .func3_i      (func3_i),
        .addr_i       (addr_i),
        .store_data_i (store_data_i),
        .stall_o      (stall_o),
        .load_data_o  (load_data_o),
        .load_valid_o (load_valid_o),
        .err_o        (err_o),
        .misalign_o   (misalign_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_be_o     (mem_be_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference rules, written from the access-size arithmetic.
    function automatic bit m_legal(input bit st, input int f3);
        if (st) return f3 <= 2;
        return f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5;
    endfunction

    function automatic int m_size(input int f3);
        return f3 % 4;
    endfunction

    function automatic int m_off(input int f3, input logic [31:0] a);
        if (m_size(f3) == 0) return int'(a % 4);
        if (m_size(f3) == 1) return int'(a & 2);
        return 0;
    endfunction

    function automatic bit m_misaligned(input int f3, input logic [31:0] a);
        return (m_size(f3) == 1 && (a % 2) != 0) || (m_size(f3) == 2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] m_be(input int f3, input logic [31:0] a);
        if (m_size(f3) == 0) return 32'(1 << m_off(f3, a));
        if (m_size(f3) == 1) return 32'(3 << m_off(f3, a));
        return 32'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] d);
        if (m_size(f3) == 0) return (d & 32'hFF) * 32'h01010101;
        if (m_size(f3) == 1) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int f3, input int off, input logic [31:0] rd);
        logic [31:0] s;
        logic [31:0] v;
        s = rd >> (8 * off);
        v = 32'h0;
        case (f3)
            0: begin v = s & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFFFF00; end
            4: v = s & 32'hFF;
            1: begin v = s & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF0000; end
            5: v = s & 32'hFFFF;
            2: v = s;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    // Drives one instruction starting at a falling edge in IDLE; returns at a falling edge in IDLE.
    task automatic run_op(input logic [6:0] op, input int f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int lat);
        bit ld, st, ok, mis, tmo, fin;
        int k;
        ld  = (op == OP_LD);
        st  = (op == OP_ST);
        ok  = m_legal(st, f3);
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = ok && m_misaligned(f3, addr);
`endif
        tmo = 1'b0;
        valid_i      = 1'b1;
        opcode_i     = op;
        func3_i      = 3'(f3);
        addr_i       = addr;
        store_data_i = sdata;
        #1 check("stall_issue", stall_o, ld || st);
        @(negedge clk);
        valid_i      = 1'b0;
        opcode_i     = 7'($urandom);
        func3_i      = 3'($urandom);
        addr_i       = $urandom;
        store_data_i = $urandom;
        if (!(ld || st)) begin
            check("req_ignored", mem_req_o, 1'b0);
            check("stall_ignored", stall_o, 1'b0);
            return;
        end
        if (ok && !mis) begin
            k   = 0;
            fin = 1'b0;
            while (!fin) begin
                check("busy_req", mem_req_o, 1'b1);
                check("busy_stall", stall_o, 1'b1);
                check("busy_we", mem_we_o, st);
                check("busy_addr", mem_addr_o, addr & 32'hFFFFFFFC);
                check("busy_be", mem_be_o, m_be(f3, addr));
                if (st) check("busy_wdata", mem_wdata_o, m_wdata(f3, sdata));
                mem_ack_i   = (k == lat);
                mem_rdata_i = (k == lat) ? rdata : $urandom;
                if (k == lat) begin
                    fin = 1'b1;
                end else if (k == TMO - 1) begin
                    fin = 1'b1;
                    tmo = 1'b1;
                end
                k++;
                @(negedge clk);
            end
            mem_ack_i = 1'b0;
        end
        if (ld) exp_q.push_back((ok && !mis && !tmo) ? m_load(f3, m_off(f3, addr), rdata) : 32'h0);
        // Inputs must be ignored while the result is presented.
        valid_i  = 1'b1;
        opcode_i = OP_ST;
        #1;
        if (ld) held_ld = exp_q.pop_front();
        check("done_stall", stall_o, 1'b0);
        check("done_req", mem_req_o, 1'b0);
        check("done_lvalid", load_valid_o, ld && ok && !mis && !tmo);
        check("done_err", err_o, !ok || tmo);
        check("done_misalign", misalign_o, mis);
        check("done_ldata", load_data_o, held_ld);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check("idle_lvalid", load_valid_o, 1'b0);
        check("idle_err", err_o, 1'b0);
        check("idle_stall", stall_o, 1'b0);
        check("idle_ldata", load_data_o, held_ld);
    endtask

    initial begin
        logic [6:0] op;
        int sel;
        rst          = 1'b1;
        valid_i      = 1'b0;
        opcode_i     = 7'h0;
        func3_i      = 3'h0;
        addr_i       = 32'h0;
        store_data_i = 32'h0;
        mem_rdata_i  = 32'h0;
        mem_ack_i    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req", mem_req_o, 1'b0);
        check("rst_stall", stall_o, 1'b0);
        check("rst_ldata", load_data_o, 32'h0);
        check("rst_lvalid", load_valid_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_misalign", misalign_o, 1'b0);
        check("rst_be", mem_be_o, 4'h0);
        check("rst_addr", mem_addr_o, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(OP_ST, 2, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        run_op(OP_LD, 0, 32'h203, 32'h0, 32'h80112233, 0);
        run_op(OP_LD, 4, 32'h203, 32'h0, 32'h80112233, 1);
        run_op(OP_LD, 1, 32'h202, 32'h0, 32'h80011234, 2);
        run_op(OP_ST, 1, 32'h202, 32'h0000ABCD, 32'h0, 0);
        run_op(OP_LD, 2, 32'h300, 32'h0, 32'h12345678, 100);
        run_op(OP_ST, 0, 32'h301, 32'h000000A5, 32'h0, 100);
        run_op(OP_LD, 2, 32'h102, 32'h0, 32'hCAFEF00D, 1);
        run_op(OP_ST, 1, 32'h103, 32'h00001357, 32'h0, 0);
        run_op(OP_LD, 3, 32'h400, 32'h0, 32'h11111111, 0);
        run_op(OP_ST, 5, 32'h400, 32'h22222222, 32'h0, 0);
        run_op(OP_ALU, 2, 32'h500, 32'h0, 32'h0, 0);

        // Reset while the bus request is outstanding.
        valid_i  = 1'b1;
        opcode_i = OP_LD;
        func3_i  = 3'd2;
        addr_i   = 32'h40;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        check("pre_rst_req", mem_req_o, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_req", mem_req_o, 1'b0);
        check("midrst_stall", stall_o, 1'b0);
        check("midrst_ldata", load_data_o, 32'h0);
        held_ld = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(OP_ST, 2, 32'h104, 32'h01234567, 32'h0, 1);

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 7);
            op  = (sel < 4) ? OP_LD : (sel < 7) ? OP_ST : OP_ALU;
            run_op(op, $urandom_range(0, 7), $urandom, $urandom, $urandom, $urandom_range(0, 5));
        end

        check("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
